// File: rtl/ccc_cfg_pkg.sv
// Shared encodings, widths and FSM states for the CCC dynamic-configuration APB master.
package ccc_cfg_pkg;

  localparam int unsigned CCC_AW = 6;
  localparam int unsigned CCC_DW = 8;

  localparam logic [1:0] CCC_OP_WR     = 2'b00;
  localparam logic [1:0] CCC_OP_RD     = 2'b01;
  localparam logic [1:0] CCC_OP_RELOCK = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StAccess,
    StResp,
    StPllRst,
    StLockWait
  } ccc_cfg_state_t;

endpackage

// File: rtl/ccc_lock_sync.sv
// Two-flop synchronizer bringing the asynchronous CCC lock into the PCLK domain.
module ccc_lock_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic lock_i,
  output logic locked_o
);

  logic meta_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q   <= 1'b0;
      locked_o <= 1'b0;
    end else begin
      meta_q   <= lock_i;
      locked_o <= meta_q;
    end
  end

endmodule

// File: rtl/ccc_apb_cfg_master.sv
// APB initiator for the fabric CCC configuration port, with PLL reset / lock-wait sequencing.
module ccc_apb_cfg_master
  import ccc_cfg_pkg::*;
#(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT = 4096,
  parameter int unsigned BUSY_TIMEOUT = 64
) (
  input  logic              PCLK,
  input  logic              PRESET_N,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic [1:0]        CMD_OP,
  input  logic [CCC_AW-1:0] CMD_ADDR,
  input  logic [CCC_DW-1:0] CMD_WDATA,
  output logic              RSP_VALID,
  output logic [CCC_DW-1:0] RSP_RDATA,
  output logic              RSP_ERR,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [CCC_AW-1:0] PADDR,
  output logic [CCC_DW-1:0] PWDATA,
  input  logic [CCC_DW-1:0] PRDATA,
  input  logic              BUSY,
  output logic              PLL_ARST_N,
  input  logic              LOCK,
  output logic              LOCKED
);

  localparam int unsigned RW = $clog2(RST_CYCLES + 1);
  localparam int unsigned LW = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned BW = $clog2(BUSY_TIMEOUT + 1);

  localparam logic [RW-1:0] RstLast  = RW'(RST_CYCLES - 1);
  localparam logic [LW-1:0] LockLast = LW'(LOCK_TIMEOUT - 1);
  localparam logic [LW-1:0] LockMax  = LW'(LOCK_TIMEOUT);
  localparam logic [BW-1:0] BusyLast = BW'(BUSY_TIMEOUT - 1);

  ccc_cfg_state_t state_q;
  logic [1:0]     op_q;
  logic [RW-1:0]  rst_cnt_q;
  logic [LW-1:0]  lock_cnt_q;
  logic [BW-1:0]  busy_cnt_q;
  logic           seen_low_q;

  ccc_lock_sync u_lock_sync (
    .clk_i    (PCLK),
    .rst_ni   (PRESET_N),
    .lock_i   (LOCK),
    .locked_o (LOCKED)
  );

  always_ff @(posedge PCLK) begin
    if (!PRESET_N) begin
      state_q    <= StIdle;
      op_q       <= CCC_OP_WR;
      rst_cnt_q  <= '0;
      lock_cnt_q <= '0;
      busy_cnt_q <= '0;
      seen_low_q <= 1'b0;
      CMD_READY  <= 1'b1;
      RSP_VALID  <= 1'b0;
      RSP_RDATA  <= '0;
      RSP_ERR    <= 1'b0;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
      PLL_ARST_N <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (CMD_VALID && CMD_READY) begin
            op_q      <= CMD_OP;
            CMD_READY <= 1'b0;
            case (CMD_OP)
              CCC_OP_WR, CCC_OP_RD: begin
                state_q    <= StSetup;
                PSEL       <= 1'b1;
                PENABLE    <= 1'b0;
                PWRITE     <= (CMD_OP == CCC_OP_WR);
                PADDR      <= CMD_ADDR;
                PWDATA     <= CMD_WDATA;
                busy_cnt_q <= '0;
              end
              CCC_OP_RELOCK: begin
                state_q    <= StPllRst;
                PLL_ARST_N <= 1'b0;
                rst_cnt_q  <= '0;
                seen_low_q <= 1'b0;
              end
              default: begin
                state_q   <= StResp;
                RSP_VALID <= 1'b1;
                RSP_ERR   <= 1'b1;
                RSP_RDATA <= '0;
              end
            endcase
          end
        end
        StSetup: begin
          state_q <= StAccess;
          PENABLE <= 1'b1;
        end
        StAccess: begin
          if (!BUSY) begin
            state_q   <= StResp;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            RSP_VALID <= 1'b1;
            RSP_ERR   <= 1'b0;
            RSP_RDATA <= (op_q == CCC_OP_RD) ? PRDATA : '0;
          end else if (busy_cnt_q == BusyLast) begin
            // Responder never finished: abandon the transfer rather than hang the port.
            state_q   <= StResp;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            RSP_VALID <= 1'b1;
            RSP_ERR   <= 1'b1;
            RSP_RDATA <= '0;
          end else begin
            busy_cnt_q <= busy_cnt_q + 1'b1;
          end
        end
        StResp: begin
          state_q   <= StIdle;
          RSP_VALID <= 1'b0;
          RSP_ERR   <= 1'b0;
          RSP_RDATA <= '0;
          CMD_READY <= 1'b1;
        end
        StPllRst: begin
          if (!LOCKED) seen_low_q <= 1'b1;
          if (rst_cnt_q == RstLast) begin
            state_q    <= StLockWait;
            PLL_ARST_N <= 1'b1;
            lock_cnt_q <= '0;
          end else begin
            rst_cnt_q <= rst_cnt_q + 1'b1;
          end
        end
        StLockWait: begin
          if (!LOCKED) seen_low_q <= 1'b1;
          // A lock left over from before the reset only counts once the wait has aged.
          if (LOCKED && (seen_low_q || lock_cnt_q >= LW'(2))) begin
            state_q   <= StResp;
            RSP_VALID <= 1'b1;
            RSP_ERR   <= 1'b0;
            RSP_RDATA <= '0;
          end else if (lock_cnt_q == LockLast) begin
            state_q   <= StResp;
            RSP_VALID <= 1'b1;
            RSP_ERR   <= 1'b1;
            RSP_RDATA <= '0;
          end else if (lock_cnt_q != LockMax) begin
            lock_cnt_q <= lock_cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ccc_apb_cfg_master.sv
// Scoreboard bench for ccc_apb_cfg_master: APB write/read, busy timeout, relock and reset abort.
module tb_ccc_apb_cfg_master;
  import ccc_cfg_pkg::*;

  logic              PCLK;
  logic              PRESET_N;
  logic              CMD_VALID;
  logic              CMD_READY;
  logic [1:0]        CMD_OP;
  logic [CCC_AW-1:0] CMD_ADDR;
  logic [CCC_DW-1:0] CMD_WDATA;
  logic              RSP_VALID;
  logic [CCC_DW-1:0] RSP_RDATA;
  logic              RSP_ERR;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [CCC_AW-1:0] PADDR;
  logic [CCC_DW-1:0] PWDATA;
  logic [CCC_DW-1:0] PRDATA;
  logic              BUSY;
  logic              PLL_ARST_N;
  logic              LOCK;
  logic              LOCKED;

  typedef struct packed {
    logic              err;
    logic [CCC_DW-1:0] rdata;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  ccc_apb_cfg_master #(
    .RST_CYCLES   (16),
    .LOCK_TIMEOUT (4096),
    .BUSY_TIMEOUT (8)
  ) dut (
    .PCLK       (PCLK),
    .PRESET_N   (PRESET_N),
    .CMD_VALID  (CMD_VALID),
    .CMD_READY  (CMD_READY),
    .CMD_OP     (CMD_OP),
    .CMD_ADDR   (CMD_ADDR),
    .CMD_WDATA  (CMD_WDATA),
    .RSP_VALID  (RSP_VALID),
    .RSP_RDATA  (RSP_RDATA),
    .RSP_ERR    (RSP_ERR),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .PADDR      (PADDR),
    .PWDATA     (PWDATA),
    .PRDATA     (PRDATA),
    .BUSY       (BUSY),
    .PLL_ARST_N (PLL_ARST_N),
    .LOCK       (LOCK),
    .LOCKED     (LOCKED)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  // Leaves the bench one cycle after the accepting edge (cycle 1).
  task automatic issue(input logic [1:0] op, input logic [5:0] addr, input logic [7:0] data);
    check_eq("ready_before_cmd", 32'(CMD_READY), 32'd1);
    CMD_VALID = 1'b1;
    CMD_OP    = op;
    CMD_ADDR  = addr;
    CMD_WDATA = data;
    step();
    CMD_VALID = 1'b0;
  endtask

  // Response scoreboard: every RSP_VALID pulse must match the oldest expected entry.
  always @(negedge PCLK) begin
    if (PRESET_N && RSP_VALID) begin
      if (exp_q.size() == 0) begin
        check_eq("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        check_eq("rsp_err", 32'(RSP_ERR), 32'(e.err));
        check_eq("rsp_rdata", 32'(RSP_RDATA), 32'(e.rdata));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    int acc;
    int t_rise;

    PRESET_N  = 1'b0;
    CMD_VALID = 1'b0;
    CMD_OP    = 2'b00;
    CMD_ADDR  = '0;
    CMD_WDATA = '0;
    PRDATA    = '0;
    BUSY      = 1'b0;
    LOCK      = 1'b0;
    step();
    step();
    check_eq("rst_cmd_ready", 32'(CMD_READY), 32'd1);
    check_eq("rst_psel", 32'({PSEL, PENABLE, PWRITE}), 32'd0);
    check_eq("rst_paddr_pwdata", 32'({PADDR, PWDATA}), 32'd0);
    check_eq("rst_rsp", 32'({RSP_VALID, RSP_ERR, RSP_RDATA}), 32'd0);
    check_eq("rst_pll_arst_n", 32'(PLL_ARST_N), 32'd1);
    check_eq("rst_locked", 32'(LOCKED), 32'd0);
    PRESET_N = 1'b1;
    step();

    // Write 0x2A to 0x05, no wait states.
    exp_q.push_back('{err: 1'b0, rdata: 8'h00});
    issue(CCC_OP_WR, 6'h05, 8'h2A);
    check_eq("wr_c1_psel_pen", 32'({PSEL, PENABLE}), 32'b10);
    check_eq("wr_c1_paddr", 32'(PADDR), 32'h05);
    check_eq("wr_c1_pwdata", 32'(PWDATA), 32'h2A);
    check_eq("wr_c1_pwrite", 32'(PWRITE), 32'd1);
    check_eq("wr_c1_ready", 32'(CMD_READY), 32'd0);
    step();
    check_eq("wr_c2_psel_pen", 32'({PSEL, PENABLE}), 32'b11);
    check_eq("wr_c2_hold", 32'({PWRITE, PADDR, PWDATA}), 32'({1'b1, 6'h05, 8'h2A}));
    step();
    check_eq("wr_c3_rsp_valid", 32'(RSP_VALID), 32'd1);
    check_eq("wr_c3_ready", 32'(CMD_READY), 32'd0);
    // Command offered during the response pulse must be ignored.
    CMD_VALID = 1'b1;
    CMD_OP    = CCC_OP_RD;
    step();
    CMD_VALID = 1'b0;
    check_eq("wr_c4_not_accepted", 32'(PSEL), 32'd0);
    check_eq("wr_c4_ready", 32'(CMD_READY), 32'd1);
    check_eq("wr_c4_rsp_low", 32'(RSP_VALID), 32'd0);

    // Read 0x11, BUSY high for three ACCESS cycles.
    BUSY   = 1'b1;
    PRDATA = 8'hC3;
    exp_q.push_back('{err: 1'b0, rdata: 8'hC3});
    issue(CCC_OP_RD, 6'h11, 8'h00);
    check_eq("rd_c1_pwrite_paddr", 32'({PWRITE, PADDR}), 32'({1'b0, 6'h11}));
    t   = 1;
    acc = 0;
    while (!RSP_VALID && t < 50) begin
      step();
      t++;
      if (t == 5) BUSY = 1'b0;
      if (PENABLE) acc++;
    end
    check_eq("rd_access_cycles", 32'(acc), 32'd4);
    check_eq("rd_rsp_cycle", 32'(t), 32'd6);
    check_eq("rd_rdata_at_rsp", 32'(RSP_RDATA), 32'hC3);
    step();
    check_eq("rd_rdata_cleared", 32'(RSP_RDATA), 32'd0);

    // BUSY stuck high: abort after eight ACCESS cycles, read data suppressed.
    BUSY   = 1'b1;
    PRDATA = 8'hFF;
    exp_q.push_back('{err: 1'b1, rdata: 8'h00});
    issue(CCC_OP_RD, 6'h3F, 8'h00);
    t   = 1;
    acc = 0;
    while (!RSP_VALID && t < 100) begin
      step();
      t++;
      if (PENABLE) acc++;
    end
    check_eq("to_access_cycles", 32'(acc), 32'd8);
    check_eq("to_rsp_cycle", 32'(t), 32'd10);
    check_eq("to_psel_pen_dropped", 32'({PSEL, PENABLE}), 32'd0);
    check_eq("to_rsp_err", 32'(RSP_ERR), 32'd1);
    BUSY = 1'b0;
    step();

    // Relock: lock arrives 100 cycles after reset release.
    exp_q.push_back('{err: 1'b0, rdata: 8'h00});
    issue(CCC_OP_RELOCK, 6'h00, 8'h00);
    check_eq("rl_c1_arst", 32'(PLL_ARST_N), 32'd0);
    t   = 1;
    acc = 0;
    while (!PLL_ARST_N && t < 100) begin
      acc++;
      step();
      t++;
    end
    check_eq("rl_arst_low_cycles", 32'(acc), 32'd16);
    check_eq("rl_arst_rise_cycle", 32'(t), 32'd17);
    acc = 0;
    for (int k = 0; k < 100; k++) begin
      if (RSP_VALID) acc++;
      step();
    end
    check_eq("rl_no_early_rsp", 32'(acc), 32'd0);
    LOCK = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      check_eq("rl_rsp_timing", 32'(RSP_VALID), 32'(k == 3));
      check_eq("rl_locked_lag", 32'(LOCKED), 32'(k >= 2));
    end
    step();
    LOCK = 1'b0;
    step();
    step();
    step();
    check_eq("rl_locked_low", 32'(LOCKED), 32'd0);

    // Relock with lock never returning: error exactly LOCK_TIMEOUT cycles after release.
    exp_q.push_back('{err: 1'b1, rdata: 8'h00});
    issue(CCC_OP_RELOCK, 6'h00, 8'h00);
    t = 1;
    while (!PLL_ARST_N && t < 100) begin
      step();
      t++;
    end
    t_rise = t;
    while (!RSP_VALID && t < t_rise + 5000) begin
      step();
      t++;
    end
    check_eq("lt_latency", 32'(t - t_rise), 32'd4096);
    check_eq("lt_err", 32'(RSP_ERR), 32'd1);
    step();

    // Reset pulsed during PLL reset: outputs return to reset values, no response.
    issue(CCC_OP_RELOCK, 6'h00, 8'h00);
    step();
    step();
    check_eq("ra_arst_low", 32'(PLL_ARST_N), 32'd0);
    PRESET_N = 1'b0;
    step();
    check_eq("ra_arst_high", 32'(PLL_ARST_N), 32'd1);
    check_eq("ra_ready", 32'(CMD_READY), 32'd1);
    check_eq("ra_rsp_valid", 32'(RSP_VALID), 32'd0);
    check_eq("ra_psel", 32'(PSEL), 32'd0);
    PRESET_N = 1'b1;
    for (int k = 0; k < 30; k++) step();
    check_eq("ra_idle_ready", 32'(CMD_READY), 32'd1);

    // Reserved op: immediate error, no bus activity.
    exp_q.push_back('{err: 1'b1, rdata: 8'h00});
    issue(2'b11, 6'h2B, 8'h99);
    check_eq("rs_c1_rsp", 32'({RSP_VALID, RSP_ERR}), 32'b11);
    acc = 0;
    for (int k = 0; k < 3; k++) begin
      if (PSEL || PENABLE) acc++;
      step();
    end
    check_eq("rs_no_apb", 32'(acc), 32'd0);

    check_eq("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
